arbiter_puf_eval_ctrl: RTL and testbench

ARBITER_PUF_EVAL_CTRL -- requirements
Module: arbiter_puf_eval_ctrl

---
 rtl/arbiter_puf_pkg.sv | 24 ++
 rtl/arbiter_puf_vote.sv | 63 ++++++
 rtl/arbiter_puf_eval_ctrl.sv | 145 ++++++++++++++
 tb/tb_arbiter_puf_eval_ctrl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/arbiter_puf_pkg.sv
// Shared definitions for the arbiter PUF evaluation controller.
// Holds the parameter defaults, the controller state encoding and the
// vote-counter width helper used by both the top and the per-chain voter.
package arbiter_puf_pkg;

    localparam int unsigned DefLength = 16;
    localparam int unsigned DefChains = 4;
    localparam int unsigned DefRepeat = 7;
    localparam int unsigned DefSettle = 4;

    typedef enum logic [2:0] {
        StIdle,
        StLow,
        StHigh,
        StCapture,
        StDone
    } puf_state_e;

    // Wide enough to hold every count from 0 up to repeat_n inclusive.
    function automatic int unsigned vote_width(input int unsigned repeat_n);
        return $clog2(repeat_n + 1);
    endfunction

endpackage

// File: rtl/arbiter_puf_vote.sv
// Per-chain arbiter sampler and vote counter.
// Ports:
//   iclk      clock
//   irst      synchronous active-high reset
//   iarb      raw arbiter output, asynchronous to iclk
//   iclear    clear the vote counter (new challenge accepted)
//   icapture  add the synchronised arbiter bit to the counter this cycle
//   ifinal    last capture of the challenge; latch the vote result
//   oresponse majority vote of all captures
//   ostable   all captures agreed
module arbiter_puf_vote
    import arbiter_puf_pkg::*;
#(
    parameter int unsigned C_REPEAT = DefRepeat
) (
    input  logic iclk,
    input  logic irst,
    input  logic iarb,
    input  logic iclear,
    input  logic icapture,
    input  logic ifinal,
    output logic oresponse,
    output logic ostable
);

    localparam int unsigned CntW = vote_width(C_REPEAT);

    logic [1:0]      sync_q;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            resp_q, stable_q;

    // Saturate rather than wrap; the controller never issues more than
    // C_REPEAT captures, so saturation is only a safety net.
    always_comb begin
        cnt_d = cnt_q;
        if (iclear) begin
            cnt_d = '0;
        end else if (icapture && sync_q[1] && (cnt_q != CntW'(C_REPEAT))) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge iclk) begin
        if (irst) begin
            sync_q   <= '0;
            cnt_q    <= '0;
            resp_q   <= 1'b0;
            stable_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], iarb};
            cnt_q  <= cnt_d;
            // Evaluate on the post-capture count so the final vote is included.
            if (ifinal) begin
                resp_q   <= (cnt_d > CntW'(C_REPEAT / 2));
                stable_q <= (cnt_d == '0) || (cnt_d == CntW'(C_REPEAT));
            end
        end
    end

    assign oresponse = resp_q;
    assign ostable   = stable_q;

endmodule

// File: rtl/arbiter_puf_eval_ctrl.sv
// Arbiter PUF evaluation controller.
// Accepts a challenge, drives it with a low/high launch pulse onto the
// external delay lines C_REPEAT times, captures each chain's arbiter output
// after every pulse and returns a per-chain majority vote plus stability flag.
// Ports:
//   iclk, irst       clock, synchronous active-high reset
//   ivalid/oready    challenge handshake, ichallenge is the challenge
//   opulse           launch pulse to every delay line
//   ochallenge_line  registered challenge to every delay line
//   iarb             raw arbiter outputs (asynchronous)
//   ovalid/iready    response handshake
//   oresponse        majority-voted bit per chain
//   ostable          per chain, all votes agreed
module arbiter_puf_eval_ctrl
    import arbiter_puf_pkg::*;
#(
    parameter int unsigned C_LENGTH = DefLength,
    parameter int unsigned C_CHAINS = DefChains,
    parameter int unsigned C_REPEAT = DefRepeat,
    parameter int unsigned C_SETTLE = DefSettle
) (
    input  logic                iclk,
    input  logic                irst,
    input  logic                ivalid,
    input  logic [C_LENGTH-1:0] ichallenge,
    output logic                oready,
    output logic                opulse,
    output logic [C_LENGTH-1:0] ochallenge_line,
    input  logic [C_CHAINS-1:0] iarb,
    output logic                ovalid,
    input  logic                iready,
    output logic [C_CHAINS-1:0] oresponse,
    output logic [C_CHAINS-1:0] ostable
);

    if ((C_REPEAT % 2) == 0 || C_REPEAT < 1) begin : g_bad_repeat
        $error("C_REPEAT must be odd and at least 1");
    end
    if (C_SETTLE < 3) begin : g_bad_settle
        $error("C_SETTLE must be at least 3");
    end

    localparam int unsigned RepW = vote_width(C_REPEAT);
    localparam int unsigned PhW  = $clog2(C_SETTLE);
    localparam logic [PhW-1:0]  SettleMax = PhW'(C_SETTLE - 1);
    localparam logic [RepW-1:0] RepLast   = RepW'(C_REPEAT - 1);

    puf_state_e          state_q, state_d;
    logic [PhW-1:0]      phase_q, phase_d;
    logic [RepW-1:0]     rep_q, rep_d;
    logic [C_LENGTH-1:0] chal_q, chal_d;
    logic                pulse_q;
    logic                accept, capture, finish;

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        rep_d   = rep_q;
        chal_d  = chal_q;
        accept  = 1'b0;
        capture = 1'b0;
        finish  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (ivalid) begin
                    accept  = 1'b1;
                    chal_d  = ichallenge;
                    rep_d   = '0;
                    phase_d = '0;
                    state_d = StLow;
                end
            end
            StLow: begin
                if (phase_q == SettleMax) begin
                    phase_d = '0;
                    state_d = StHigh;
                end else begin
                    phase_d = phase_q + PhW'(1);
                end
            end
            StHigh: begin
                if (phase_q == SettleMax) begin
                    phase_d = '0;
                    state_d = StCapture;
                end else begin
                    phase_d = phase_q + PhW'(1);
                end
            end
            StCapture: begin
                capture = 1'b1;
                rep_d   = rep_q + RepW'(1);
                if (rep_q == RepLast) begin
                    finish  = 1'b1;
                    state_d = StDone;
                end else begin
                    state_d = StLow;
                end
            end
            StDone: begin
                if (iready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge iclk) begin
        if (irst) begin
            state_q <= StIdle;
            phase_q <= '0;
            rep_q   <= '0;
            chal_q  <= '0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            rep_q   <= rep_d;
            chal_q  <= chal_d;
            // Registered so the launch edge into the delay lines is glitch-free.
            pulse_q <= (state_d == StHigh);
        end
    end

    for (genvar k = 0; k < C_CHAINS; k++) begin : g_chain
        arbiter_puf_vote #(
            .C_REPEAT(C_REPEAT)
        ) u_vote (
            .iclk     (iclk),
            .irst     (irst),
            .iarb     (iarb[k]),
            .iclear   (accept),
            .icapture (capture),
            .ifinal   (finish),
            .oresponse(oresponse[k]),
            .ostable  (ostable[k])
        );
    end

    assign oready          = (state_q == StIdle);
    assign ovalid          = (state_q == StDone);
    assign opulse          = pulse_q;
    assign ochallenge_line = chal_q;

endmodule

// File: tb/tb_arbiter_puf_eval_ctrl.sv
// Directed bench for arbiter_puf_eval_ctrl with C_CHAINS=2, C_REPEAT=3,
// C_SETTLE=3 (latency 21, back-to-back period 23).
module tb_arbiter_puf_eval_ctrl;

    logic        iclk = 1'b0;
    logic        irst;
    logic        ivalid;
    logic [15:0] ichallenge;
    logic        oready;
    logic        opulse;
    logic [15:0] ochallenge_line;
    logic [1:0]  iarb;
    logic        ovalid;
    logic        iready;
    logic [1:0]  oresponse;
    logic [1:0]  ostable;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int last_valid = 0;
    int prev_valid = 0;

    arbiter_puf_eval_ctrl #(
        .C_LENGTH(16),
        .C_CHAINS(2),
        .C_REPEAT(3),
        .C_SETTLE(3)
    ) u_dut (
        .iclk           (iclk),
        .irst           (irst),
        .ivalid         (ivalid),
        .ichallenge     (ichallenge),
        .oready         (oready),
        .opulse         (opulse),
        .ochallenge_line(ochallenge_line),
        .iarb           (iarb),
        .ovalid         (ovalid),
        .iready         (iready),
        .oresponse      (oresponse),
        .ostable        (ostable)
    );

    always #5 iclk = ~iclk;
    always @(posedge iclk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge iclk);
        #1;
    endtask

    // One full evaluation; returns sitting in DONE (k=21 after acceptance).
    task automatic run_eval(input string tag, input logic [15:0] chal,
                            input logic [1:0] a0, input logic [1:0] a1, input logic [1:0] a2,
                            input logic [1:0] er, input logic [1:0] es, input bit hold_valid);
        logic [1:0]  seq [3];
        logic [20:0] pulse_seen;
        bit          bad_chal, bad_busy;
        seq[0] = a0; seq[1] = a1; seq[2] = a2;
        ichallenge = chal;
        iarb       = a0;
        ivalid     = 1'b1;
        for (int i = 0; i < 50 && !oready; i++) tick(1);
        check_eq({tag, "_ready"}, {31'd0, oready}, 32'd1);
        tick(1);
        if (!hold_valid) ivalid = 1'b0;
        pulse_seen = '0;
        bad_chal   = 1'b0;
        bad_busy   = 1'b0;
        for (int k = 0; k < 21; k++) begin
            if (k % 7 == 0) iarb = seq[k / 7];
            if (k == 1) ichallenge = ~chal;
            pulse_seen[k] = opulse;
            if (ochallenge_line !== chal) bad_chal = 1'b1;
            if (ovalid !== 1'b0 || oready !== 1'b0) bad_busy = 1'b1;
            tick(1);
        end
        check_eq({tag, "_pulse"}, {11'd0, pulse_seen}, {11'd0, 21'b011100001110000111000});
        check_eq({tag, "_chal_hold"}, {31'd0, bad_chal}, 32'd0);
        check_eq({tag, "_busy_flags"}, {31'd0, bad_busy}, 32'd0);
        check_eq({tag, "_valid"}, {31'd0, ovalid}, 32'd1);
        check_eq({tag, "_resp"}, {30'd0, oresponse}, {30'd0, er});
        check_eq({tag, "_stable"}, {30'd0, ostable}, {30'd0, es});
        check_eq({tag, "_chal"}, {16'd0, ochallenge_line}, {16'd0, chal});
        prev_valid = last_valid;
        last_valid = cyc;
    endtask

    initial begin
        bit bad;
        irst       = 1'b1;
        ivalid     = 1'b0;
        iready     = 1'b0;
        iarb       = 2'b00;
        ichallenge = 16'h0000;
        tick(2);
        irst = 1'b0;
        check_eq("rst_ready", {31'd0, oready}, 32'd1);
        check_eq("rst_valid", {31'd0, ovalid}, 32'd0);
        check_eq("rst_pulse", {31'd0, opulse}, 32'd0);
        check_eq("rst_chal", {16'd0, ochallenge_line}, 32'd0);
        check_eq("rst_resp", {30'd0, oresponse}, 32'd0);
        check_eq("rst_stable", {30'd0, ostable}, 32'd0);

        // Constant arbiter pattern.
        iready = 1'b1;
        run_eval("const", 16'hA5C3, 2'b10, 2'b10, 2'b10, 2'b10, 2'b11, 1'b0);
        tick(1);
        check_eq("const_idle_ready", {31'd0, oready}, 32'd1);
        check_eq("const_idle_valid", {31'd0, ovalid}, 32'd0);

        // Mixed votes, then back-pressure on the response.
        iready = 1'b0;
        run_eval("mixed", 16'h1234, 2'b01, 2'b00, 2'b11, 2'b01, 2'b00, 1'b0);
        ivalid     = 1'b1;
        ichallenge = 16'hFFFF;
        bad        = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (ovalid !== 1'b1 || oready !== 1'b0 || oresponse !== 2'b01 ||
                ostable !== 2'b00 || ochallenge_line !== 16'h1234) bad = 1'b1;
        end
        check_eq("hold_stable", {31'd0, bad}, 32'd0);
        ivalid = 1'b0;
        iready = 1'b1;
        tick(1);
        iready = 1'b0;
        check_eq("release_ready", {31'd0, oready}, 32'd1);
        check_eq("release_valid", {31'd0, ovalid}, 32'd0);

        // Reset during the second HIGH phase.
        ichallenge = 16'h0F0F;
        iarb       = 2'b11;
        ivalid     = 1'b1;
        tick(1);
        ivalid = 1'b0;
        tick(10);
        check_eq("abort_in_high", {31'd0, opulse}, 32'd1);
        irst = 1'b1;
        tick(1);
        check_eq("abort_pulse", {31'd0, opulse}, 32'd0);
        check_eq("abort_ready", {31'd0, oready}, 32'd1);
        check_eq("abort_valid", {31'd0, ovalid}, 32'd0);
        check_eq("abort_chal", {16'd0, ochallenge_line}, 32'd0);
        check_eq("abort_resp", {30'd0, oresponse}, 32'd0);
        check_eq("abort_stable", {30'd0, ostable}, 32'd0);
        irst = 1'b0;
        bad  = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick(1);
            if (ovalid !== 1'b0) bad = 1'b1;
        end
        check_eq("abort_no_valid", {31'd0, bad}, 32'd0);

        iready = 1'b1;
        run_eval("post_rst", 16'hC0DE, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 1'b0);
        tick(1);

        // Continuous ivalid with iready held high.
        run_eval("b2b0", 16'h1111, 2'b10, 2'b10, 2'b10, 2'b10, 2'b11, 1'b1);
        run_eval("b2b1", 16'h2222, 2'b11, 2'b01, 2'b00, 2'b01, 2'b00, 1'b1);
        check_eq("b2b1_period", last_valid - prev_valid, 32'd23);
        run_eval("b2b2", 16'h3333, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 1'b1);
        check_eq("b2b2_period", last_valid - prev_valid, 32'd23);
        ivalid = 1'b0;
        tick(2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
